// File: rtl/bist_vec_reader.sv
// bist_vec_reader: walks the BIST vector memory from address 0 and hands each word to the test
// driver as a (cmd, data) vector over a valid/ready handshake. This block only reads the memory.
// The walk stops on an end marker (0x0000), on an illegal opcode, on abort, or after the last
// address.
//
// Ports:
//   clk, res_n          rising-edge clock, asynchronous active-low reset
//   start, abort        walk control pulses; abort wins over everything else
//   mem_adr, mem_dout   combinational memory read port
//   vec_valid/ready     vector handshake; vec_cmd, vec_data, vec_sep carry the vector
//   busy, done, err     status levels
//   vec_cnt, grp_cnt    vectors and separators accepted since the last start
module bist_vec_reader #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 16
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         start,
  input  logic         abort,
  output logic [N-1:0] mem_adr,
  input  logic [M-1:0] mem_dout,
  output logic         vec_valid,
  input  logic         vec_ready,
  output logic [7:0]   vec_cmd,
  output logic [7:0]   vec_data,
  output logic         vec_sep,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N:0]   vec_cnt,
  output logic [N-1:0] grp_cnt
);

  typedef enum logic [2:0] {StIdle, StFetch, StPresent, StDone, StErr} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] adr_q, adr_d;
  logic         valid_q, valid_d;
  logic [7:0]   cmd_q, cmd_d;
  logic [7:0]   data_q, data_d;
  logic         sep_q, sep_d;
  logic [N:0]   vcnt_q, vcnt_d;
  logic [N-1:0] gcnt_q, gcnt_d;

  logic [7:0] word_cmd;
  logic       word_is_vec;

  assign word_cmd    = mem_dout[M-1:M-8];
  // Legal vectors: opcodes 0x10..0x1F with any operand, or the exact separator word 0x2000.
  assign word_is_vec = (word_cmd[7:4] == 4'h1) || (mem_dout == M'(16'h2000));

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    sep_d   = sep_q;
    vcnt_d  = vcnt_q;
    gcnt_d  = gcnt_q;
    if (abort) begin
      // Counters keep their values so software can see how far the walk got.
      state_d = StIdle;
      valid_d = 1'b0;
      adr_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            adr_d   = '0;
            vcnt_d  = '0;
            gcnt_d  = '0;
            state_d = StFetch;
          end
        end
        StFetch: begin
          if (mem_dout == '0) begin
            state_d = StDone;
          end else if (word_is_vec) begin
            cmd_d   = word_cmd;
            data_d  = mem_dout[7:0];
            sep_d   = (word_cmd == 8'h20);
            valid_d = 1'b1;
            state_d = StPresent;
          end else begin
            // adr_q is left pointing at the offending word.
            state_d = StErr;
          end
        end
        StPresent: begin
          if (vec_ready) begin
            valid_d = 1'b0;
            vcnt_d  = vcnt_q + 1'b1;
            if (sep_q && (gcnt_q != '1)) begin
              gcnt_d = gcnt_q + 1'b1;
            end
            if (adr_q == '1) begin
              state_d = StDone;
            end else begin
              adr_d   = adr_q + 1'b1;
              state_d = StFetch;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= StIdle;
      adr_q   <= '0;
      valid_q <= 1'b0;
      cmd_q   <= '0;
      data_q  <= '0;
      sep_q   <= 1'b0;
      vcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      sep_q   <= sep_d;
      vcnt_q  <= vcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign mem_adr   = adr_q;
  assign vec_valid = valid_q;
  assign vec_cmd   = cmd_q;
  assign vec_data  = data_q;
  assign vec_sep   = sep_q;
  assign vec_cnt   = vcnt_q;
  assign grp_cnt   = gcnt_q;
  assign busy      = (state_q == StFetch) || (state_q == StPresent);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StErr);

endmodule

// File: tb/tb_bist_vec_reader.sv
// Bench for bist_vec_reader: table of single-image walks, hand-written corner sequences, and
// random images checked against a walk model computed straight from the memory contents.
module tb_bist_vec_reader;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  mem_adr;
  logic [15:0] mem_dout;
  logic        vec_valid;
  logic        vec_ready = 1'b0;
  logic [7:0]  vec_cmd, vec_data;
  logic        vec_sep, busy, done, err;
  logic [8:0]  vec_cnt;
  logic [7:0]  grp_cnt;

  logic [15:0] mem [256];
  assign mem_dout = mem[mem_adr];

  always #5 clk = ~clk;

  bist_vec_reader #(.N(8), .M(16)) dut (
    .clk(clk), .res_n(res_n), .start(start), .abort(abort),
    .mem_adr(mem_adr), .mem_dout(mem_dout),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_cmd(vec_cmd), .vec_data(vec_data), .vec_sep(vec_sep),
    .busy(busy), .done(done), .err(err), .vec_cnt(vec_cnt), .grp_cnt(grp_cnt)
  );

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
    logic       sep;
  } vec_t;

  vec_t got_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Accepted vectors and stall stability, sampled mid-cycle.
  logic stall_prev = 1'b0;
  vec_t vec_prev;
  always @(negedge clk) begin
    if (!res_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_held", int'(vec_valid), 1);
        chk("stall_vec_held", int'({vec_cmd, vec_data, vec_sep}), int'(vec_prev));
      end
      if (vec_valid && vec_ready && !abort) got_q.push_back('{vec_cmd, vec_data, vec_sep});
      stall_prev = vec_valid && !vec_ready && !abort;
      vec_prev   = '{vec_cmd, vec_data, vec_sep};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference walk over the memory image.
  task automatic model(output vec_t exp_q[$], output bit e_done, output bit e_err,
                       output int e_adr, output int e_cnt, output int e_grp);
    int a = 0;
    int seps = 0;
    exp_q.delete();
    e_done = 0;
    e_err  = 0;
    forever begin
      logic [15:0] w = mem[a];
      if (w == 16'h0000) begin e_done = 1; break; end
      if (w[15:12] == 4'h1 || w == 16'h2000) begin
        exp_q.push_back('{w[15:8], w[7:0], w == 16'h2000});
        if (w == 16'h2000) seps++;
        if (a == 255) begin e_done = 1; break; end
        a++;
      end else begin
        e_err = 1;
        break;
      end
    end
    e_adr = a;
    e_cnt = exp_q.size();
    e_grp = (seps > 255) ? 255 : seps;
  endtask

  task automatic begin_walk();
    got_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input bit rand_ready);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (done || err) break;
      vec_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
    end
    if (i == 2000) chk("walk_timeout", 0, 1);
  endtask

  task automatic check_final(input string tag);
    vec_t exp_q[$];
    bit   e_done, e_err;
    int   e_adr, e_cnt, e_grp;
    int   bad = -1;
    model(exp_q, e_done, e_err, e_adr, e_cnt, e_grp);
    chk({tag, "_nvec"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] != exp_q[i] && bad < 0) bad = i;
    end
    chk({tag, "_first_bad_vec"}, bad, -1);
    chk({tag, "_done"}, int'(done), int'(e_done));
    chk({tag, "_err"}, int'(err), int'(e_err));
    chk({tag, "_adr"}, int'(mem_adr), e_adr);
    chk({tag, "_vec_cnt"}, int'(vec_cnt), e_cnt);
    chk({tag, "_grp_cnt"}, int'(grp_cnt), e_grp);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic run_walk(input string tag, input bit rand_ready);
    begin_walk();
    wait_end(rand_ready);
    check_final(tag);
  endtask

  task automatic load_t2();
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0] = 16'h2000;
    mem[1] = 16'h1201;
    mem[2] = 16'h1A13;
  endtask

  typedef struct {
    logic [15:0] w0, w1;
    bit          e_done, e_err;
    int          e_adr, e_cnt, e_grp;
  } row_t;

  row_t tbl[10];

  initial begin
    tbl[0] = '{16'h0000, 16'h0000, 1, 0, 0, 0, 0};
    tbl[1] = '{16'h1000, 16'h0000, 1, 0, 1, 1, 0};
    tbl[2] = '{16'h1FFF, 16'h0000, 1, 0, 1, 1, 0};
    tbl[3] = '{16'h2000, 16'h0000, 1, 0, 1, 1, 1};
    tbl[4] = '{16'h2001, 16'h0000, 0, 1, 0, 0, 0};
    tbl[5] = '{16'h0F00, 16'h0000, 0, 1, 0, 0, 0};
    tbl[6] = '{16'h2100, 16'h0000, 0, 1, 0, 0, 0};
    tbl[7] = '{16'h0001, 16'h0000, 0, 1, 0, 0, 0};
    tbl[8] = '{16'h1234, 16'h2000, 1, 0, 2, 2, 1};
    tbl[9] = '{16'h1500, 16'hFFFF, 0, 1, 1, 1, 0};

    foreach (mem[i]) mem[i] = 16'h0000;

    // Reset state.
    #2;
    chk("rst_valid", int'(vec_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_adr", int'(mem_adr), 0);
    chk("rst_cnts", int'({vec_cnt, grp_cnt}), 0);
    step();
    res_n = 1'b1;
    step();

    // Table of short images, ready tied high.
    foreach (tbl[k]) begin
      foreach (mem[i]) mem[i] = 16'h0000;
      mem[0] = tbl[k].w0;
      mem[1] = tbl[k].w1;
      begin_walk();
      wait_end(1'b0);
      chk($sformatf("tbl%0d_done", k), int'(done), int'(tbl[k].e_done));
      chk($sformatf("tbl%0d_err", k), int'(err), int'(tbl[k].e_err));
      chk($sformatf("tbl%0d_adr", k), int'(mem_adr), tbl[k].e_adr);
      chk($sformatf("tbl%0d_vec_cnt", k), int'(vec_cnt), tbl[k].e_cnt);
      chk($sformatf("tbl%0d_grp_cnt", k), int'(grp_cnt), tbl[k].e_grp);
    end

    // T2: latency and basic walk.
    load_t2();
    vec_ready = 1'b1;
    begin_walk();
    chk("t2_valid_lat1", int'(vec_valid), 0);
    chk("t2_busy", int'(busy), 1);
    step();
    chk("t2_valid_lat2", int'(vec_valid), 1);
    chk("t2_first_vec", int'({vec_cmd, vec_data, vec_sep}), int'({8'h20, 8'h00, 1'b1}));
    wait_end(1'b0);
    check_final("t2");
    chk("t2_adr_const", int'(mem_adr), 3);

    // T3: stall on vector 2.
    vec_ready = 1'b0;
    begin_walk();
    step();
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    step();
    repeat (5) begin
      chk("t3_held_valid", int'(vec_valid), 1);
      chk("t3_held_vec", int'({vec_cmd, vec_data}), 16'h1201);
      step();
    end
    wait_end(1'b0);
    check_final("t3");
    chk("t3_vec_cnt_const", int'(vec_cnt), 3);

    // T4: illegal opcode after one vector.
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0] = 16'h2000;
    mem[1] = 16'h3355;
    run_walk("t4", 1'b0);
    chk("t4_err_const", int'({err, mem_adr}), int'({1'b1, 8'd1}));

    // T5: abort on vector 2 while ready is high.
    load_t2();
    vec_ready = 1'b1;
    begin_walk();
    step();
    step();
    step();
    chk("t5_pre_abort_valid", int'(vec_valid), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_valid", int'(vec_valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_vec_cnt", int'(vec_cnt), 1);
    chk("t5_adr", int'(mem_adr), 0);
    chk("t5_ndelivered", got_q.size(), 1);
    run_walk("t5_restart", 1'b0);

    // T1: reset mid-PRESENT with a nonzero count.
    load_t2();
    vec_ready = 1'b1;
    begin_walk();
    step();
    step();
    vec_ready = 1'b0;
    step();
    chk("t1_pre_cnt", int'(vec_cnt), 1);
    chk("t1_pre_valid", int'(vec_valid), 1);
    #2 res_n = 1'b0;
    #1;
    chk("t1_valid", int'(vec_valid), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_adr", int'(mem_adr), 0);
    chk("t1_cnts", int'({vec_cnt, grp_cnt}), 0);
    step();
    res_n = 1'b1;
    vec_ready = 1'b1;
    repeat (4) step();
    chk("t1_no_resume", int'({busy, vec_valid, done, err}), 0);

    // T6: full memory of vectors, then a rerun from DONE.
    foreach (mem[i]) mem[i] = 16'h1F41;
    run_walk("t6", 1'b0);
    chk("t6_cnt_const", int'(vec_cnt), 256);
    run_walk("t6_rerun", 1'b1);

    // Separator counter saturation.
    foreach (mem[i]) mem[i] = 16'h2000;
    run_walk("sat", 1'b0);
    chk("sat_grp_const", int'(grp_cnt), 255);

    // Random images, random ready.
    for (int it = 0; it < 20; it++) begin
      int len = (it == 0) ? 256 : $urandom_range(1, 40);
      foreach (mem[i]) mem[i] = 16'h0000;
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 15);
        if (r <= 10 || r == 15) mem[i] = {4'h1, 12'($urandom)};
        else if (r <= 13) mem[i] = 16'h2000;
        else mem[i] = {4'(3 + $urandom_range(0, 11)), 12'($urandom)};
      end
      run_walk($sformatf("rnd%0d", it), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
